axi_clint_timer: RTL
====================

# axi_clint_timer

AXI4 slave peripheral providing a 64-bit machine timer (`mtime`/`mtimecmp`) and a level timer interrupt for the core. It is a leaf on one crossbar master port, alongside the memory, UART and exit decoder. It drives the core's timer interrupt line, which is currently tied to zero at the memory-mapped RAM level. Register access is single-beat, 32-bit only.

## Interface
- `AXI_ADDR_WIDTH`, 32, address width of the slave port
- `AXI_DATA_WIDTH`, 32, data width; only 32 is supported
- `AXI_ID_WIDTH`, 16, ID width; IDs are echoed on B and R
- `AXI_USER_WIDTH`, 10, user width; user outputs are driven to 0
- `PRESCALE`, 25, clock cycles per `mtime` increment; must be ≥1
- `clk_i`  in  1  single system clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `AXI_Slave`  AXI_BUS.Slave  —  register port
- `timer_irq_o`  out  1  level machine-timer interrupt
- `sw_irq_o`  out  1  software interrupt; present only with `CLINT_MSIP_EN`

## Operation
- Decode uses `addr[4:2]`; upper bits are ignored because the crossbar has already selected this block. The crossbar window is 0x20 bytes.
- Register map:
  - 0x00 `MTIME_LO`, RW
  - 0x04 `MTIME_HI`, RW
  - 0x08 `MTIMECMP_LO`, RW
  - 0x0C `MTIMECMP_HI`, RW
  - 0x10 `CTRL`, RW; bit0 = count enable, other bits read 0
  - 0x14 `MSIP`, RW bit0; only with `CLINT_MSIP_EN`
- Undecoded offsets: reads return 0 with SLVERR; writes are dropped with SLVERR.
- Write strobes apply per byte on all RW registers.
- Prescaler:
  - 0..PRESCALE-1 counter advances while `CTRL.en`=1.
  - On wrap, `mtime` increments by 1 as a full 64-bit value, carrying into HI.
  - `CTRL.en`=0 freezes both the prescaler and `mtime`.
- `timer_irq_o` = (`mtime` >= `mtimecmp`, unsigned 64-bit compare), registered, and independent of `CTRL.en`.
- FSM states: IDLE, W_DRAIN, B_RESP, R_RESP.
  - IDLE, AW and W valid together → assert awready/wready; perform the write; wlast=1 → B_RESP, else → W_DRAIN.
  - IDLE, AR valid and no complete write pending → assert arready → R_RESP.
  - W_DRAIN: accept W beats without writing them until wlast, then → B_RESP.
  - B_RESP: bvalid until bready → IDLE.
  - R_RESP: rvalid with rlast=1 until rready → IDLE.
- Bursts (len≠0):
  - Writes: only the first beat is applied; bresp=SLVERR.
  - Reads: a single beat with rlast=1 and SLVERR. Masters must not issue read bursts.
- Arbitration: write wins over read when both are valid in IDLE.
- Simultaneous SW write and increment: the SW write takes the written word. The other word of `mtime` holds and does not increment that cycle, so no carry is lost into a freshly written word.

## Timing
- Reset values:
  - `mtime`=0, prescaler=0, `mtimecmp`=all-ones, `CTRL.en`=1, `MSIP`=0
  - `timer_irq_o`=0, `sw_irq_o`=0
  - all AXI ready and valid outputs 0
- Write latency: AW/W handshake at cycle N; register updated at the N+1 edge; bvalid high from N+1.
- Read latency: AR handshake at cycle N; rvalid and rdata, sampled at N, stable from N+1 until rready.
- Interrupt latency: `timer_irq_o` reflects the compare one cycle after `mtime`/`mtimecmp` change.
- At most one outstanding transaction; readies are low outside IDLE/W_DRAIN.
- Async reset mid-transaction aborts it immediately; no response is issued.

## Configuration
- `CLINT_MSIP_EN`
  - Defined: offset 0x14 implements `MSIP` bit0, driven on `sw_irq_o`, OKAY response.
  - Undefined: `sw_irq_o` port is absent; 0x14 behaves as undecoded (SLVERR, read 0).

## Test plan
- Reset, then read 0x0C and 0x08 → 0xFFFFFFFF OKAY; `timer_irq_o`=0; `mtime` starts counting.
- PRESCALE=4:
  - Write `MTIME_LO`=0xFFFFFFFE and `MTIME_HI`=0 → after 8 cycles `MTIME_HI` reads 1 and `MTIME_LO` reads 0.
- Write `MTIMECMP`=0x0000_0000_0000_0010 → `timer_irq_o` rises within 1 cycle of `mtime` reaching 0x10. Rewrite `MTIMECMP_LO`=0xFFFFFFFF → `timer_irq_o` drops the next cycle.
- Write `CTRL`=0 → two reads of `MTIME_LO` 100 cycles apart return equal values.
- Mixed accesses:
  - AW+W and AR asserted in the same cycle → write handled first (B), then read (R) with the new value.
  - AWLEN=3 → 4 W beats accepted, bresp=SLVERR, only beat 0 applied.
  - Read of 0x18 → SLVERR, rdata 0.
  - Read of 0x14 → OKAY or SLVERR per `CLINT_MSIP_EN`.
- Assert `rst_ni`=0 while bvalid is pending and bready=0 → bvalid=0 immediately and all registers return to their reset values.

Source files
------------

// File: rtl/axi_clint_timer_if.sv
// AXI4 bus bundle for the machine-timer slave port.
// Master modport drives requests, Slave modport drives responses.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
    input  b_id, b_resp, b_user, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid, input ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid, output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid, output w_ready,
    output b_id, b_resp, b_user, b_valid, input b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
  );
endinterface

// File: rtl/axi_clint_timer.sv
// AXI4 slave machine timer: 64-bit mtime/mtimecmp with a prescaled count
// and a registered level timer interrupt. Single-beat 32-bit registers.
// Optional MSIP software interrupt register enabled by `CLINT_MSIP_EN.
module axi_clint_timer #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10,
  parameter int unsigned PRESCALE       = 25
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  AXI_BUS.Slave  AXI_Slave,
  output logic   timer_irq_o
`ifdef CLINT_MSIP_EN
  ,
  output logic   sw_irq_o
`endif
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, W_DRAIN, B_RESP, R_RESP} state_t;
  state_t state_q, state_d;

  logic [63:0]             mtime_q, mtimecmp_q;
  logic [PW-1:0]           presc_q;
  logic                    ctrl_en_q, irq_q, tick;
  logic                    wr_hs, rd_hs, wr_dec, rd_dec;
  logic [2:0]              wr_idx, rd_idx;
  logic [31:0]             wr_lo, wr_hi, wr_cmp_lo, wr_cmp_hi;
  logic [AXI_DATA_WIDTH-1:0] rd_data;
  logic [AXI_ID_WIDTH-1:0] b_id_q, r_id_q;
  logic [1:0]              b_resp_q, r_resp_q;
  logic [AXI_DATA_WIDTH-1:0] r_data_q;
`ifdef CLINT_MSIP_EN
  logic                    msip_q;
`endif

  // Per-byte merge of a write into a 32-bit register word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = strb[b] ? wd[b*8 +: 8] : old[b*8 +: 8];
    return r;
  endfunction

  // A complete write (AW+W) always wins over a read in IDLE.
  assign wr_hs  = (state_q == IDLE) && AXI_Slave.aw_valid && AXI_Slave.w_valid;
  assign rd_hs  = (state_q == IDLE) && AXI_Slave.ar_valid &&
                  !(AXI_Slave.aw_valid && AXI_Slave.w_valid);
  assign wr_idx = AXI_Slave.aw_addr[4:2];
  assign rd_idx = AXI_Slave.ar_addr[4:2];
`ifdef CLINT_MSIP_EN
  assign wr_dec = (wr_idx <= 3'd5);
`else
  assign wr_dec = (wr_idx <= 3'd4);
`endif

  assign wr_lo     = merge(mtime_q[31:0],     AXI_Slave.w_data[31:0], AXI_Slave.w_strb[3:0]);
  assign wr_hi     = merge(mtime_q[63:32],    AXI_Slave.w_data[31:0], AXI_Slave.w_strb[3:0]);
  assign wr_cmp_lo = merge(mtimecmp_q[31:0],  AXI_Slave.w_data[31:0], AXI_Slave.w_strb[3:0]);
  assign wr_cmp_hi = merge(mtimecmp_q[63:32], AXI_Slave.w_data[31:0], AXI_Slave.w_strb[3:0]);
  assign tick      = ctrl_en_q && (presc_q == PW'(PRESCALE - 1));

  // Read mux; undecoded offsets return zero and flag the error.
  always_comb begin
    rd_data = '0;
    rd_dec  = 1'b1;
    case (rd_idx)
      3'd0: rd_data[31:0] = mtime_q[31:0];
      3'd1: rd_data[31:0] = mtime_q[63:32];
      3'd2: rd_data[31:0] = mtimecmp_q[31:0];
      3'd3: rd_data[31:0] = mtimecmp_q[63:32];
      3'd4: rd_data[0]    = ctrl_en_q;
`ifdef CLINT_MSIP_EN
      3'd5: rd_data[0]    = msip_q;
`endif
      default: rd_dec = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d            = state_q;
    AXI_Slave.aw_ready = wr_hs;
    AXI_Slave.w_ready  = wr_hs || (state_q == W_DRAIN);
    AXI_Slave.ar_ready = rd_hs;
    AXI_Slave.b_valid  = (state_q == B_RESP);
    AXI_Slave.r_valid  = (state_q == R_RESP);
    case (state_q)
      IDLE:    if (wr_hs)      state_d = AXI_Slave.w_last ? B_RESP : W_DRAIN;
               else if (rd_hs) state_d = R_RESP;
      W_DRAIN: if (AXI_Slave.w_valid && AXI_Slave.w_last) state_d = B_RESP;
      B_RESP:  if (AXI_Slave.b_ready) state_d = IDLE;
      R_RESP:  if (AXI_Slave.r_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response capture: IDs echoed, bursts and undecoded offsets get SLVERR.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_id_q   <= '0;
      b_resp_q <= RESP_OKAY;
      r_id_q   <= '0;
      r_resp_q <= RESP_OKAY;
      r_data_q <= '0;
    end else begin
      if (wr_hs) begin
        b_id_q   <= AXI_Slave.aw_id;
        b_resp_q <= (wr_dec && AXI_Slave.aw_len == 8'd0) ? RESP_OKAY : RESP_SLVERR;
      end
      if (rd_hs) begin
        r_id_q   <= AXI_Slave.ar_id;
        r_resp_q <= (rd_dec && AXI_Slave.ar_len == 8'd0) ? RESP_OKAY : RESP_SLVERR;
        r_data_q <= rd_data;
      end
    end
  end

  // Timer state: a SW write to one mtime word pre-empts the increment, so
  // the other word holds and no carry lands in a freshly written word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      presc_q    <= '0;
      ctrl_en_q  <= 1'b1;
      irq_q      <= 1'b0;
    end else begin
      if (ctrl_en_q) presc_q <= tick ? '0 : presc_q + PW'(1);
      if (wr_hs && wr_idx == 3'd0)      mtime_q[31:0]  <= wr_lo;
      else if (wr_hs && wr_idx == 3'd1) mtime_q[63:32] <= wr_hi;
      else if (tick)                    mtime_q        <= mtime_q + 64'd1;
      if (wr_hs && wr_idx == 3'd2) mtimecmp_q[31:0]  <= wr_cmp_lo;
      if (wr_hs && wr_idx == 3'd3) mtimecmp_q[63:32] <= wr_cmp_hi;
      if (wr_hs && wr_idx == 3'd4 && AXI_Slave.w_strb[0]) ctrl_en_q <= AXI_Slave.w_data[0];
      irq_q <= (mtime_q >= mtimecmp_q);
    end
  end

`ifdef CLINT_MSIP_EN
  // Software interrupt bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) msip_q <= 1'b0;
    else if (wr_hs && wr_idx == 3'd5 && AXI_Slave.w_strb[0]) msip_q <= AXI_Slave.w_data[0];
  end
  assign sw_irq_o = msip_q;
`endif

  assign timer_irq_o      = irq_q;
  assign AXI_Slave.b_id   = b_id_q;
  assign AXI_Slave.b_resp = b_resp_q;
  assign AXI_Slave.b_user = '0;
  assign AXI_Slave.r_id   = r_id_q;
  assign AXI_Slave.r_data = r_data_q;
  assign AXI_Slave.r_resp = r_resp_q;
  assign AXI_Slave.r_last = 1'b1;
  assign AXI_Slave.r_user = '0;

  logic unused_ok;
  assign unused_ok = ^{AXI_Slave.aw_addr[AXI_ADDR_WIDTH-1:5], AXI_Slave.aw_addr[1:0],
                       AXI_Slave.ar_addr[AXI_ADDR_WIDTH-1:5], AXI_Slave.ar_addr[1:0],
                       AXI_Slave.aw_size, AXI_Slave.aw_burst, AXI_Slave.aw_user,
                       AXI_Slave.ar_size, AXI_Slave.ar_burst, AXI_Slave.ar_user,
                       AXI_Slave.w_user, AXI_Slave.w_data, AXI_Slave.w_strb};

endmodule
